// File: rtl/i2c_pad_filter_pkg.sv
// Shared constants and helpers for the I2C pad conditioning front end.
// Optional glitch statistics are enabled with the I2C_GLITCH_STAT_EN macro.
package i2c_filt_pkg;

  // Level of an idle (released) I2C line.
  localparam logic IDLE_LVL = 1'b1;

  // Default synchroniser depth and stable-count filter length.
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_LEN    = 4;

  // Width of the stable counter: clog2(filt_len), never narrower than one bit.
  function automatic int cnt_w(input int filt_len);
    int w;
    w = $clog2(filt_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/i2c_pad_filter_line.sv
// One I2C line: pad synchroniser followed by a stable-count glitch filter.
// With I2C_GLITCH_STAT_EN defined, a rejection flag is also exported.
module i2c_line_filter
  import i2c_filt_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic filt
`ifdef I2C_GLITCH_STAT_EN
  ,
  output logic rej
`endif
);

  localparam int              CW      = cnt_w(FILT_LEN);
  localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p0;
  logic [CW-1:0]          cnt_p1;

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage 0: bring the asynchronous pad into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= {SYNC_STAGES{IDLE_LVL}};
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pad};
    end
  end

  // Stage 1: a new level must persist FILT_LEN synced samples before it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt   <= IDLE_LVL;
      cnt_p1 <= '0;
    end else if (s_p0 == filt) begin
      cnt_p1 <= '0;
    end else if (cnt_p1 == CNT_MAX) begin
      filt   <= s_p0;
      cnt_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_p1 + CW'(1);
    end
  end

`ifdef I2C_GLITCH_STAT_EN
  // A pending change that collapses back to the filtered level is a rejected pulse.
  assign rej = (s_p0 == filt) && (cnt_p1 != '0);
`endif

endmodule

// File: rtl/i2c_pad_filter.sv
// I2C pad conditioning: filtered SCL/SDA, SCL edges, START/STOP and bus-busy.
// Define I2C_GLITCH_STAT_EN to add GLITCH_CLR/GLITCH_CNT rejected-pulse statistics.
module i2c_pad_filter
  import i2c_filt_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN
`ifdef I2C_GLITCH_STAT_EN
  ,
  parameter int STAT_W      = 8
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCL_IN,
  input  logic              SDA_IN,
  output logic              SCL_F,
  output logic              SDA_F,
  output logic              SCL_RISE,
  output logic              SCL_FALL,
  output logic              START_DET,
  output logic              STOP_DET,
  output logic              BUS_BUSY
`ifdef I2C_GLITCH_STAT_EN
  ,
  input  logic              GLITCH_CLR,
  output logic [STAT_W-1:0] GLITCH_CNT
`endif
);

  logic scl_f_p1;
  logic sda_f_p1;
`ifdef I2C_GLITCH_STAT_EN
  logic scl_rej;
  logic sda_rej;
`endif

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_scl (
    .clk  (CLK),
    .rst  (RST),
    .pad  (SCL_IN),
    .filt (scl_f_p1)
`ifdef I2C_GLITCH_STAT_EN
    ,
    .rej  (scl_rej)
`endif
  );

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sda (
    .clk  (CLK),
    .rst  (RST),
    .pad  (SDA_IN),
    .filt (sda_f_p1)
`ifdef I2C_GLITCH_STAT_EN
    ,
    .rej  (sda_rej)
`endif
  );

  // Stage 2: publish filtered levels together with their edge/condition pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SCL_F     <= IDLE_LVL;
      SDA_F     <= IDLE_LVL;
      SCL_RISE  <= 1'b0;
      SCL_FALL  <= 1'b0;
      START_DET <= 1'b0;
      STOP_DET  <= 1'b0;
    end else begin
      SCL_F     <= scl_f_p1;
      SDA_F     <= sda_f_p1;
      SCL_RISE  <= scl_f_p1 & ~SCL_F;
      SCL_FALL  <= ~scl_f_p1 & SCL_F;
      // SCL must be high on both sides of the SDA edge, so a joint change never counts.
      START_DET <= SCL_F & scl_f_p1 & SDA_F & ~sda_f_p1;
      STOP_DET  <= SCL_F & scl_f_p1 & ~SDA_F & sda_f_p1;
    end
  end

  // Bus ownership tracks the registered START/STOP pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BUS_BUSY <= 1'b0;
    end else if (START_DET) begin
      BUS_BUSY <= 1'b1;
    end else if (STOP_DET) begin
      BUS_BUSY <= 1'b0;
    end
  end

`ifdef I2C_GLITCH_STAT_EN
  logic [1:0] rej_sum;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [1:0]        inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + (STAT_W + 1)'(inc);
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

  assign rej_sum = {1'b0, scl_rej} + {1'b0, sda_rej};

  // Saturating count of rejected pulses; clear beats a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (RST || GLITCH_CLR) begin
      GLITCH_CNT <= '0;
    end else begin
      GLITCH_CNT <= sat_add(GLITCH_CNT, rej_sum);
    end
  end
`endif

endmodule

// File: doc/i2c_pad_filter.md
Name: i2c_pad_filter

Overview:
- Front-end conditioning stage between the raw I2C pads (SCL/SDA) and the DUT's I2C slave engine.
- Synchronises both lines into the CLK domain and removes glitches with a digital stable-count filter.
- Decodes filtered SCL edges, START and STOP conditions, and bus-busy status for the downstream protocol FSM.
- Glitch behaviour here is what the glitch and TG assertion sets observe at the slave input.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per line; legal range 2..4.
- FILT_LEN, 4: consecutive synced cycles a new level must hold before it propagates; legal range 1..15.
- STAT_W, 8: width of the glitch statistics counter; used only with the optional feature.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous reset, active-high.
- SCL_IN  in  1  raw SCL pad input, asynchronous.
- SDA_IN  in  1  raw SDA pad input, asynchronous.
- SCL_F  out  1  filtered SCL.
- SDA_F  out  1  filtered SDA.
- SCL_RISE  out  1  one-cycle pulse on SCL_F 0->1.
- SCL_FALL  out  1  one-cycle pulse on SCL_F 1->0.
- START_DET  out  1  one-cycle pulse on a START or repeated START.
- STOP_DET  out  1  one-cycle pulse on a STOP.
- BUS_BUSY  out  1  high between START and STOP.
- GLITCH_CLR  in  1  synchronous clear of GLITCH_CNT (I2C_GLITCH_STAT_EN only).
- GLITCH_CNT  out  STAT_W  saturating count of rejected pulses (I2C_GLITCH_STAT_EN only).

Behaviour:
- Reset values (RST sampled high on a CLK edge):
  - all synchroniser flops and SCL_F/SDA_F = 1 (idle bus);
  - filter counters = 0;
  - SCL_RISE/SCL_FALL/START_DET/STOP_DET/BUS_BUSY = 0;
  - GLITCH_CNT = 0.
- Reset mid-transfer discards any in-progress count, drops BUS_BUSY and emits no STOP_DET.
- Per-line filter, applied to the synced input s against the filtered output f:
  - if s == f: counter <= 0;
  - else if counter == FILT_LEN-1: f <= s and counter <= 0;
  - else counter <= counter+1.
- Latency: a clean pad level change appears on SCL_F/SDA_F exactly SYNC_STAGES+FILT_LEN cycles after the first CLK edge that samples it. With defaults this is 6 cycles.
- A pulse held for fewer than FILT_LEN synced cycles is rejected. f is unchanged, and the rejection event occurs in the cycle s returns to f while counter != 0.
- Edge and condition outputs are registered and assert in the same cycle the new f value appears:
  - SCL_RISE/SCL_FALL follow SCL_F transitions;
  - START_DET = SDA_F 1->0 while SCL_F is 1 both before and after that edge;
  - STOP_DET = SDA_F 0->1 under the same SCL_F condition.
- Simultaneous SCL_F and SDA_F change in one cycle: SCL edge pulse only, no START_DET/STOP_DET.
- BUS_BUSY: set on START_DET, cleared on STOP_DET. A repeated START while busy re-pulses START_DET and BUS_BUSY stays 1.
- START_DET and STOP_DET are mutually exclusive by construction.
- FILT_LEN=1: a new synced level passes on the next cycle and no glitch is ever rejected.

Optional Feature:
- Macro: I2C_GLITCH_STAT_EN.
- Defined:
  - GLITCH_CLR and GLITCH_CNT exist.
  - Each cycle GLITCH_CNT adds the number of lines (0, 1 or 2) that signalled a rejection, saturating at 2^STAT_W-1.
  - GLITCH_CLR forces 0 and wins over a same-cycle increment.
- Undefined: both ports, the counter and the rejection logic are absent. Filtering, latency and all other outputs are cycle-identical to the defined build.

Decomposition:
- Package i2c_filt_pkg holds:
  - IDLE_LVL = 1'b1;
  - default FILT_LEN and SYNC_STAGES;
  - a width function for the filter counter, clog2(FILT_LEN) with a minimum of 1.
- Sub-module i2c_line_filter, instantiated twice (SCL, SDA), contains the synchroniser chain, stable counter, filtered output and reject flag.
- Edge/START/STOP decode, BUS_BUSY and the statistics counter live in the top.

Test Plan:
- Reset with RST=1 for 3 cycles while pads toggle -> SCL_F=SDA_F=1 and all pulses and BUS_BUSY 0 throughout; GLITCH_CNT=0.
- Defaults, SCL_IN 1->0 held 20 cycles -> SCL_F falls 6 cycles after first sampling edge; SCL_FALL high exactly that one cycle.
- SDA_IN low pulse of 3 cycles with SCL high -> SDA_F stays 1, no START_DET; GLITCH_CNT 0->1 (macro on).
- Same 3-cycle pulse on both lines in the same cycles -> GLITCH_CNT +2 (macro on); with GLITCH_CLR asserted on the increment cycle -> GLITCH_CNT=0.
- SDA falls with SCL high, then a byte of SCL toggles, then a repeated START, then SDA rises with SCL high -> START_DET, then 8 SCL_RISE pulses, then START_DET again with BUS_BUSY staying 1, then STOP_DET with BUS_BUSY going 0 the cycle after.
- SCL and SDA pads change on the same CLK edge -> SCL_RISE or SCL_FALL only, no START_DET/STOP_DET. Separately, RST asserted while BUS_BUSY=1 -> BUS_BUSY 0 next cycle, no STOP_DET.
